// File: rtl/log_dump_ctrl_if.sv
// Valid/ready stream carrying one I/Q word per beat from the dump controller
// to the host bridge.
interface log_dump_ctrl_if #(
  parameter int W = 32
);
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/log_dump_ctrl.sv
// Capture/dump sequencer for the dual-BRAM logger: turns host commands into
// logger run/read pulses and streams the captured words out on a dump.
module log_dump_ctrl #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int RD_LAT          = 1
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_cmd_capture,
  input  logic                         i_cmd_dump,
  input  logic [BRAM_ADDR_WIDTH-1:0]   i_dump_len,
  input  logic                         i_mem_full,
  input  logic [2*BRAM_DATA_WIDTH-1:0] i_log_data,
  output logic                         o_run_log,
  output logic                         o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0]   o_addr_log,
  log_dump_ctrl_if.master              tx,
  output logic                         o_busy,
  output logic                         o_captured,
  output logic                         o_done,
  output logic                         o_cmd_err
);
  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int WW = 2 * BRAM_DATA_WIDTH;
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_RDSTART = 3'd2,
    S_RDWAIT  = 3'd3,
    S_FETCH   = 3'd4,
    S_SEND    = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, len_q, len_d, addr_out_q, addr_out_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [WW-1:0] data_q, data_d;
  logic          full_unread_q, full_unread_d, captured_q, captured_d;
  logic          run_q, run_d, read_q, read_d, valid_q, valid_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      addr_out_q    <= '0;
      cnt_q         <= 2'd0;
      data_q        <= '0;
      full_unread_q <= 1'b0;
      captured_q    <= 1'b0;
      run_q         <= 1'b0;
      read_q        <= 1'b0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      addr_out_q    <= addr_out_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      full_unread_q <= full_unread_d;
      captured_q    <= captured_d;
      run_q         <= run_d;
      read_q        <= read_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    full_unread_d = full_unread_q;
    captured_d    = captured_q;
    run_d         = 1'b0;
    read_d        = 1'b0;
    valid_d       = valid_q;
    done_d        = 1'b0;
    // Any command outside IDLE is ignored and flagged
    err_d         = (state_q != S_IDLE) & (i_cmd_capture | i_cmd_dump);
    case (state_q)
      S_IDLE: begin
        if (i_cmd_capture) begin
          // Capture has priority; a simultaneous dump is always dropped
          err_d = i_cmd_dump | full_unread_q;
          if (!full_unread_q) begin
            run_d      = 1'b1;
            captured_d = 1'b0;
            state_d    = S_CAPTURE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (i_cmd_dump) begin
          if (captured_q) begin
            len_d   = i_dump_len;
            addr_d  = '0;
            read_d  = 1'b1;
            state_d = S_RDSTART;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (i_mem_full) begin
          captured_d    = 1'b1;
          full_unread_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_RDSTART: begin
        full_unread_d = 1'b0;
        state_d       = S_RDWAIT;
      end
      S_RDWAIT: begin
        cnt_d   = 2'd0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (cnt_q == LAT_LAST) begin
          data_d  = i_log_data;
          valid_d = 1'b1;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_SEND: begin
        if (tx.tx_ready) begin
          valid_d = 1'b0;
          // Equality-only termination so an all-ones length covers the full space
          if (addr_q == len_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = 2'd0;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    addr_out_d = ((state_d == S_FETCH) || (state_d == S_SEND)) ? addr_d : '0;
    busy_d     = (state_d != S_IDLE);
  end

  assign o_run_log   = run_q;
  assign o_read_log  = read_q;
  assign o_addr_log  = addr_out_q;
  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign o_busy      = busy_q;
  assign o_captured  = captured_q;
  assign o_done      = done_q;
  assign o_cmd_err   = err_q;
endmodule

// File: tb/tb_log_dump_ctrl.sv
// Directed bench for log_dump_ctrl at AW=4, DW=16, RD_LAT=1 with a one-cycle
// logger read model.
module tb_log_dump_ctrl;
  logic        clk = 1'b0;
  logic        rst, cmd_capture, cmd_dump, mem_full;
  logic [3:0]  dump_len;
  logic [31:0] log_data;
  logic        run_log, read_log, busy, captured, done, cmd_err;
  logic [3:0]  addr_log;
  int          total = 0;
  int          bad = 0;

  log_dump_ctrl_if #(.W(32)) tx_if ();

  log_dump_ctrl #(.BRAM_ADDR_WIDTH(4), .BRAM_DATA_WIDTH(16), .RD_LAT(1)) dut (
    .clk(clk), .i_rst(rst), .i_cmd_capture(cmd_capture), .i_cmd_dump(cmd_dump),
    .i_dump_len(dump_len), .i_mem_full(mem_full), .i_log_data(log_data),
    .o_run_log(run_log), .o_read_log(read_log), .o_addr_log(addr_log), .tx(tx_if),
    .o_busy(busy), .o_captured(captured), .o_done(done), .o_cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [3:0] a);
    return {12'hA5C, a, ~a, 12'h3E1};
  endfunction

  // Logger model: one-cycle read latency
  always @(posedge clk) log_data <= word_of(addr_log);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q_data[$];
  logic [3:0]  q_addr[$];
  int          q_cyc[$];
  int          r_read, r_run, r_err, r_stable_bad, r_first;
  bit          r_timeout, r_done_valid, r_done_busy, r_done_after;

  // Issues a dump and records handshakes; scenario tasks judge the record
  task automatic dump_run(input logic [3:0] len, input bit rnd, input int inject_at);
    int cyc; bit pv; bit fin; bit rdy; logic [31:0] pd; logic [3:0] pa;
    q_data.delete(); q_addr.delete(); q_cyc.delete();
    r_read = 0; r_run = 0; r_err = 0; r_stable_bad = 0; r_first = -1;
    pv = 1'b0; fin = 1'b0; pd = 32'd0; pa = 4'd0;
    dump_len = len; cmd_dump = 1'b1;
    tick();
    cmd_dump = 1'b0; cyc = 0;
    while (!fin && cyc < 400) begin
      cmd_capture = 1'b0;
      if (read_log) r_read++;
      if (run_log) r_run++;
      if (cmd_err) r_err++;
      if (done) begin
        fin = 1'b1; r_done_valid = tx_if.tx_valid; r_done_busy = busy;
      end else begin
        if (tx_if.tx_valid && r_first < 0) r_first = cyc;
        if (pv && (tx_if.tx_data !== pd || addr_log !== pa || tx_if.tx_valid !== 1'b1)) r_stable_bad++;
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tx_if.tx_ready = rdy;
        if (tx_if.tx_valid && rdy) begin
          q_data.push_back(tx_if.tx_data); q_addr.push_back(addr_log); q_cyc.push_back(cyc);
          pv = 1'b0;
        end else begin
          pv = tx_if.tx_valid; pd = tx_if.tx_data; pa = addr_log;
        end
        if (cyc == inject_at) cmd_capture = 1'b1;
        tick();
        cyc++;
      end
    end
    r_timeout = !fin;
    tick();
    r_done_after = done;
  endtask

  task automatic do_capture();
    cmd_capture = 1'b1;
    tick();
    cmd_capture = 1'b0; mem_full = 1'b0;
    repeat (8) tick();
    mem_full = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_capture = 1'b0; cmd_dump = 1'b0; mem_full = 1'b0;
    dump_len = 4'd0; tx_if.tx_ready = 1'b0;
    tick(); tick();
    total++;
    if ({run_log, read_log, addr_log, tx_if.tx_data, tx_if.tx_valid, busy, captured, done, cmd_err} !== 45'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {run_log, read_log, addr_log, tx_if.tx_data, tx_if.tx_valid, busy, captured, done, cmd_err});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_dump_before_capture();
    cmd_dump = 1'b1; dump_len = 4'd3;
    tick();
    cmd_dump = 1'b0;
    total++;
    if ({cmd_err, busy, read_log} !== 3'b100) begin
      bad++; $display("FAIL early_dump_err: err/busy/read=%b want 100", {cmd_err, busy, read_log});
    end
    tick();
    total++;
    if ({cmd_err, busy} !== 2'b00) begin
      bad++; $display("FAIL early_dump_pulse: err/busy=%b want 00", {cmd_err, busy});
    end
  endtask

  task automatic test_capture();
    int runs; int busy_low;
    runs = 0; busy_low = 0;
    cmd_capture = 1'b1;
    tick();
    cmd_capture = 1'b0; mem_full = 1'b0;
    total++;
    if ({run_log, busy, captured} !== 3'b110) begin
      bad++; $display("FAIL capture_start: run/busy/captured=%b want 110", {run_log, busy, captured});
    end
    repeat (31) begin
      tick();
      if (run_log) runs++;
      if (!busy || captured) busy_low++;
    end
    total++;
    if (runs !== 0 || busy_low !== 0) begin
      bad++; $display("FAIL capture_wait: extra_runs=%0d busy_gaps=%0d want 0 0", runs, busy_low);
    end
    mem_full = 1'b1;
    tick();
    total++;
    if ({captured, busy} !== 2'b10) begin
      bad++; $display("FAIL capture_end: captured/busy=%b want 10", {captured, busy});
    end
  endtask

  task automatic test_capture_full_unread();
    cmd_capture = 1'b1;
    tick();
    cmd_capture = 1'b0;
    total++;
    if ({cmd_err, run_log, busy} !== 3'b100) begin
      bad++; $display("FAIL full_unread_reject: err/run/busy=%b want 100", {cmd_err, run_log, busy});
    end
  endtask

  task automatic test_full_dump();
    dump_run(4'd15, 1'b0, -1);
    total++;
    if (r_timeout || r_read !== 1 || q_data.size() !== 16) begin
      bad++; $display("FAIL full_dump_shape: timeout=%0d reads=%0d words=%0d want 0 1 16", r_timeout, r_read, q_data.size());
    end
    total++;
    if (r_first !== 4) begin
      bad++; $display("FAIL full_dump_latency: got %0d want 4", r_first);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== word_of(4'(i)) || q_addr[i] !== 4'(i)) begin
        bad++; $display("FAIL full_dump_word%0d: data=%h addr=%0d want %h %0d", i, q_data[i], q_addr[i], word_of(4'(i)), i);
      end
      if (i > 0) begin
        total++;
        if (q_cyc[i] - q_cyc[i-1] !== 3) begin
          bad++; $display("FAIL full_dump_gap%0d: got %0d want 3", i, q_cyc[i] - q_cyc[i-1]);
        end
      end
    end
    total++;
    if ({r_done_valid, r_done_busy, r_done_after} !== 3'b000) begin
      bad++; $display("FAIL full_dump_done: valid/busy/done_next=%b want 000", {r_done_valid, r_done_busy, r_done_after});
    end
  endtask

  task automatic test_backpressure();
    dump_run(4'd3, 1'b1, -1);
    total++;
    if (r_timeout || q_data.size() !== 4 || r_stable_bad !== 0) begin
      bad++; $display("FAIL bp_shape: timeout=%0d words=%0d unstable=%0d want 0 4 0", r_timeout, q_data.size(), r_stable_bad);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== word_of(4'(i)) || q_addr[i] !== 4'(i)) begin
        bad++; $display("FAIL bp_word%0d: data=%h addr=%0d want %h %0d", i, q_data[i], q_addr[i], word_of(4'(i)), i);
      end
    end
  endtask

  task automatic test_cmd_during_dump();
    dump_run(4'd3, 1'b0, 5);
    total++;
    if (r_err !== 1 || r_run !== 0 || q_data.size() !== 4 || r_timeout) begin
      bad++; $display("FAIL busy_cmd: errs=%0d runs=%0d words=%0d want 1 0 4", r_err, r_run, q_data.size());
    end
    total++;
    if (q_data.size() == 4 && (q_data[3] !== word_of(4'd3) || q_addr[3] !== 4'd3)) begin
      bad++; $display("FAIL busy_cmd_last: data=%h addr=%0d want %h 3", q_data[3], q_addr[3], word_of(4'd3));
    end
  endtask

  task automatic test_simultaneous();
    cmd_capture = 1'b1; cmd_dump = 1'b1;
    tick();
    cmd_capture = 1'b0; cmd_dump = 1'b0; mem_full = 1'b0;
    total++;
    if ({run_log, cmd_err, captured, read_log} !== 4'b1100) begin
      bad++; $display("FAIL both_cmds: run/err/captured/read=%b want 1100", {run_log, cmd_err, captured, read_log});
    end
    repeat (5) tick();
    mem_full = 1'b1;
    tick();
    total++;
    if ({captured, busy} !== 2'b10) begin
      bad++; $display("FAIL both_cmds_capture: captured/busy=%b want 10", {captured, busy});
    end
  endtask

  task automatic test_reset_in_send();
    bit found;
    found = 1'b0;
    dump_len = 4'd15; cmd_dump = 1'b1; tx_if.tx_ready = 1'b1;
    tick();
    cmd_dump = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (tx_if.tx_valid && addr_log == 4'd5) found = 1'b1;
      else tick();
    end
    tx_if.tx_ready = 1'b0;
    tick();
    total++;
    if (!found || tx_if.tx_valid !== 1'b1) begin
      bad++; $display("FAIL reset_send_reach: found=%0d valid=%b want 1 1", found, tx_if.tx_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({run_log, read_log, addr_log, tx_if.tx_data, tx_if.tx_valid, busy, captured, done, cmd_err} !== 45'd0) begin
      bad++; $display("FAIL reset_send_outputs: got %h want 0", {run_log, read_log, addr_log, tx_if.tx_data, tx_if.tx_valid, busy, captured, done, cmd_err});
    end
    do_capture();
    dump_run(4'd2, 1'b0, -1);
    total++;
    if (r_timeout || q_data.size() !== 3 || r_first !== 4) begin
      bad++; $display("FAIL reset_redump: timeout=%0d words=%0d lat=%0d want 0 3 4", r_timeout, q_data.size(), r_first);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      total++;
      if (q_data[i] !== word_of(4'(i)) || q_addr[i] !== 4'(i)) begin
        bad++; $display("FAIL reset_redump_word%0d: data=%h addr=%0d want %h %0d", i, q_data[i], q_addr[i], word_of(4'(i)), i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dump_before_capture();
    test_capture();
    test_capture_full_unread();
    test_full_dump();
    test_backpressure();
    test_cmd_during_dump();
    test_simultaneous();
    test_reset_in_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
